// File: rtl/sccb_write_arbiter_pkg.sv
// Shared types and helpers for the SCCB register-write arbiter.
// Holds the FSM state encoding, byte width, timeout default and rr_pick().
package sccb_arb_pkg;

    localparam int DATA_W             = 8;
    localparam int TMO_W              = 22;
    localparam int TIMEOUT_CYCLES_DEF = 2700000;

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        STORE_ADDR,
        STORE_VAL,
        STORE_END,
        SEND,
        SEND_END,
        WAIT_TX,
        COMPLETE,
        FAULT
    } state_t;

    // First set bit of valid at or after ptr, wrapping mod n (n <= 8).
    // Returns ptr when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] valid,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] r;
        int         s;
        r = ptr;
        for (int k = 7; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= n)
                s = s - n;
            if (k < n && valid[s[2:0]])
                r = s[2:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sccb_write_arbiter_if.sv
// Requester-side bundle of the SCCB write arbiter.
// master: requester (valid/addr/val out, ready/done/err in); slave: arbiter.
interface sccb_write_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import sccb_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_reg_addr;
    logic [NUM_REQ*DATA_W-1:0] req_reg_val;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;

    modport master (
        output req_valid,
        output req_reg_addr,
        output req_reg_val,
        input  req_ready,
        input  req_done,
        input  req_err
    );

    modport slave (
        input  req_valid,
        input  req_reg_addr,
        input  req_reg_val,
        output req_ready,
        output req_done,
        output req_err
    );

endinterface

// File: rtl/sccb_write_arbiter_rr_arbiter.sv
// Round-robin picker: combinational pick from a registered pointer.
// Ports: clk, rst_n, valid[NUM_REQ], advance (grant taken), any_o, pick_o.
module rr_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic               any_o,
    output logic [IDX_W-1:0]   pick_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [7:0]       v8;
    logic [2:0]       p3;

    always_comb begin
        v8 = '0;
        v8[NUM_REQ-1:0] = valid;
    end

    assign p3     = rr_pick(v8, 3'(ptr_q), NUM_REQ);
    assign pick_o = IDX_W'(p3);
    assign any_o  = |valid;

    // Pointer moves just past the winner so it has lowest priority next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else if (advance)
            ptr_q <= (pick_o == IDX_W'(NUM_REQ - 1)) ? '0 : pick_o + 1'b1;
    end

endmodule

// File: rtl/sccb_write_arbiter.sv
// Shares one i2c_control_fsm byte/store/send port among NUM_REQ writers.
// Ports: sys_clk, sys_rst_n, req_bus (slave), ctrl_* to the fsm,
// busy_o, grant_idx_o. Optional watchdog: define SCCB_TIMEOUT_EN.
module sccb_write_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
`ifdef SCCB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    sccb_write_arbiter_if.slave  req_bus,
    input  logic                 ctrl_init_done_i,
    output logic [DATA_W-1:0]    ctrl_data_o,
    output logic                 ctrl_store_o,
    output logic                 ctrl_send_o,
    input  logic                 ctrl_device_rdy_i,
    input  logic                 ctrl_error_i,
    output logic                 busy_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

    state_t              state;
    logic [IDX_W-1:0]    grant_q;
    logic [DATA_W-1:0]   val_q;
    logic                fault_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [NUM_REQ-1:0]  err_q;
    logic [NUM_REQ-1:0]  ready;
    logic [NUM_REQ-1:0]  own;
    logic                any;
    logic [IDX_W-1:0]    pick;
`ifdef SCCB_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_q;
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .valid   (req_bus.req_valid),
        .advance (|ready),
        .any_o   (any),
        .pick_o  (pick)
    );

    // Ready follows live valid so a dropped request gets no accept.
    // In FAULT, accepts alternate with their done pulse.
    always_comb begin
        ready = '0;
        if (any && (state == ARB || (state == FAULT && !(|done_q))))
            ready = onehot(pick);
    end

    assign own               = onehot(grant_q);
    assign req_bus.req_ready = ready;
    assign req_bus.req_done  = done_q;
    assign req_bus.req_err   = err_q;
    assign grant_idx_o       = grant_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            grant_q      <= '0;
            val_q        <= '0;
            fault_q      <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
            ctrl_data_o  <= '0;
            ctrl_store_o <= 1'b0;
            ctrl_send_o  <= 1'b0;
            busy_o       <= 1'b0;
`ifdef SCCB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            ctrl_store_o <= 1'b0;
            ctrl_send_o  <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
            unique case (state)
                IDLE: begin
                    if (ctrl_init_done_i) begin
                        if (ctrl_error_i) begin
                            state <= FAULT;
                        end else if (any) begin
                            state  <= ARB;
                            busy_o <= 1'b1;
                        end
                    end
                end
                ARB: begin
                    if (any) begin
                        grant_q      <= pick;
                        val_q        <= req_bus.req_reg_val[DATA_W*pick +: DATA_W];
                        ctrl_data_o  <= req_bus.req_reg_addr[DATA_W*pick +: DATA_W];
                        ctrl_store_o <= 1'b1;
                        state        <= STORE_ADDR;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                STORE_ADDR: begin
                    ctrl_data_o  <= val_q;
                    ctrl_store_o <= 1'b1;
                    state        <= STORE_VAL;
                end
                STORE_VAL: begin
                    state <= STORE_END;
                end
                STORE_END: begin
                    ctrl_send_o <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    state <= SEND_END;
                end
                SEND_END: begin
                    state <= WAIT_TX;
`ifdef SCCB_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                end
                WAIT_TX: begin
                    if (ctrl_error_i) begin
                        done_q  <= own;
                        err_q   <= own;
                        fault_q <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= COMPLETE;
                    end else if (ctrl_device_rdy_i) begin
                        done_q  <= own;
                        fault_q <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= COMPLETE;
                    end
`ifdef SCCB_TIMEOUT_EN
                    // fsm error may never latch, so recover to IDLE.
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        done_q  <= own;
                        err_q   <= own;
                        fault_q <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= COMPLETE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                COMPLETE: begin
                    state <= fault_q ? FAULT : IDLE;
                end
                FAULT: begin
                    if (|ready) begin
                        grant_q <= pick;
                        done_q  <= ready;
                        err_q   <= ready;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed bench for sccb_write_arbiter with a bus-side fsm stand-in.
// Timeout case is built only when SCCB_TIMEOUT_EN is defined.
module tb_sccb_write_arbiter;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       init_done;
    logic       dev_rdy;
    logic       dev_err;
    logic [7:0] data;
    logic       store;
    logic       send;
    logic       busy;
    logic [0:0] gidx;

    sccb_write_arbiter_if #(.NUM_REQ(2)) bus ();

    sccb_write_arbiter #(
        .NUM_REQ (2)
`ifdef SCCB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (50)
`endif
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .req_bus           (bus),
        .ctrl_init_done_i  (init_done),
        .ctrl_data_o       (data),
        .ctrl_store_o      (store),
        .ctrl_send_o       (send),
        .ctrl_device_rdy_i (dev_rdy),
        .ctrl_error_i      (dev_err),
        .busy_o            (busy),
        .grant_idx_o       (gidx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    int         cyc, rdy_cyc, send_cyc, done_cyc;
    int         n_send, n_done, n_err;
    bit         send_seen, glitch;
    logic [1:0] done_v, err_v;
    int         g_q[$];
    logic [7:0] st_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        g_q.delete();
        st_q.delete();
        n_send    = 0;
        n_done    = 0;
        n_err     = 0;
        send_seen = 0;
        glitch    = 0;
        rdy_cyc   = -1;
        send_cyc  = 0;
        done_cyc  = 0;
        done_v    = '0;
        err_v     = '0;
    endtask

    task automatic do_reset();
        sys_rst_n     = 1'b0;
        dev_rdy       = 1'b0;
        dev_err       = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic req(input int i, input logic [7:0] a, input logic [7:0] v);
        bus.req_valid[i]           = 1'b1;
        bus.req_reg_addr[8*i +: 8] = a;
        bus.req_reg_val[8*i +: 8]  = v;
    endtask

    // Observe one negedge per cycle until n_target dones or budget.
    // rdy_dly/err_dly: cycles after the send pulse to raise rdy/error.
    task automatic run_txn(input int n_target, input int budget,
                           input int rdy_dly, input int err_dly);
        bit in_txn;
        in_txn = 0;
        cyc    = 0;
        for (int k = 0; k < budget && n_done < n_target; k++) begin
            @(negedge sys_clk);
            cyc++;
            if (|bus.req_ready) begin
                if (rdy_cyc < 0)
                    rdy_cyc = cyc;
                for (int i = 0; i < 2; i++)
                    if (bus.req_ready[i])
                        g_q.push_back(i);
                in_txn = 1;
            end
            if (store)
                st_q.push_back(data);
            if (send) begin
                n_send++;
                send_cyc  = cyc;
                send_seen = 1;
            end
            if (send_seen && rdy_dly >= 0 && cyc == send_cyc + rdy_dly)
                dev_rdy = 1'b1;
            if (send_seen && err_dly >= 0 && cyc == send_cyc + err_dly)
                dev_err = 1'b1;
            if (|bus.req_done) begin
                n_done++;
                done_cyc = cyc;
                done_v   = bus.req_done;
                err_v    = bus.req_err;
                if (|bus.req_err)
                    n_err++;
                in_txn = 0;
                if (rdy_dly >= 0)
                    dev_rdy = 1'b0;
            end else if (in_txn && !busy) begin
                glitch = 1;
            end
        end
        bus.req_valid = '0;
        check("done_count", n_done, n_target);
    endtask

    initial begin
        logic [7:0] exp_st[8];
        int         ready_seen;

        sys_rst_n        = 1'b0;
        init_done        = 1'b0;
        dev_rdy          = 1'b0;
        dev_err          = 1'b0;
        bus.req_valid    = '0;
        bus.req_reg_addr = '0;
        bus.req_reg_val  = '0;
        repeat (2) @(negedge sys_clk);

        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_done", 32'(bus.req_done), 0);
        check("rst_err", 32'(bus.req_err), 0);
        check("rst_data", 32'(data), 0);
        check("rst_strobes", 32'({store, send, busy}), 0);
        check("rst_gidx", 32'(gidx), 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // init_done low: requests must wait
        req(0, 8'h11, 8'h22);
        ready_seen = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if (|bus.req_ready)
                ready_seen++;
        end
        check("no_init_ready", ready_seen, 0);
        check("no_init_busy", 32'(busy), 0);
        bus.req_valid = '0;
        init_done     = 1'b1;
        @(negedge sys_clk);

        // single write, rdy 20 cycles after send
        clear_log();
        req(0, 8'h12, 8'h80);
        run_txn(1, 60, 20, -1);
        check("sw_ready_lat", rdy_cyc, 1);
        check("sw_grant", g_q.size() > 0 ? g_q[0] : -1, 0);
        check("sw_store_n", st_q.size(), 2);
        if (st_q.size() == 2) begin
            check("sw_addr", 32'(st_q[0]), 32'h12);
            check("sw_val", 32'(st_q[1]), 32'h80);
        end
        check("sw_send_n", n_send, 1);
        check("sw_done_gap", done_cyc - send_cyc, 21);
        check("sw_done_v", 32'(done_v), 1);
        check("sw_err_v", 32'(err_v), 0);

        // contention with a stale rdy held high throughout
        do_reset();
        clear_log();
        dev_rdy = 1'b1;
        req(0, 8'h20, 8'h21);
        req(1, 8'h30, 8'h31);
        run_txn(4, 100, -1, -1);
        dev_rdy = 1'b0;
        check("ct_grants_n", g_q.size(), 4);
        if (g_q.size() == 4) begin
            check("ct_g0", g_q[0], 0);
            check("ct_g1", g_q[1], 1);
            check("ct_g2", g_q[2], 0);
            check("ct_g3", g_q[3], 1);
        end
        check("ct_send_n", n_send, 4);
        check("ct_err_n", n_err, 0);
        check("ct_busy_glitch", 32'(glitch), 0);
        check("stale_done_gap", done_cyc - send_cyc, 3);
        exp_st = '{8'h20, 8'h21, 8'h30, 8'h31,
                   8'h20, 8'h21, 8'h30, 8'h31};
        check("ct_store_n", st_q.size(), 8);
        if (st_q.size() == 8)
            for (int i = 0; i < 8; i++)
                check($sformatf("ct_st%0d", i), 32'(st_q[i]), 32'(exp_st[i]));
        @(negedge sys_clk);

        // reset during STORE_VAL
        req(0, 8'h55, 8'h66);
        repeat (3) @(negedge sys_clk);
        check("mid_store", 32'({store, data}), 32'h166);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_strobes", 32'({store, send, busy}), 0);
        check("mid_data", 32'(data), 0);
        check("mid_ready", 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        repeat (2) @(negedge sys_clk);
        check("mid_done", 32'(bus.req_done), 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        clear_log();
        req(0, 8'h3A, 8'h04);
        run_txn(1, 40, 3, -1);
        check("post_store_n", st_q.size(), 2);
        if (st_q.size() == 2) begin
            check("post_addr", 32'(st_q[0]), 32'h3A);
            check("post_val", 32'(st_q[1]), 32'h04);
        end
        check("post_done_v", 32'(done_v), 1);
        check("post_err_v", 32'(err_v), 0);
        check("post_done_gap", done_cyc - send_cyc, 4);

`ifdef SCCB_TIMEOUT_EN
        // watchdog: no rdy, 50 WAIT_TX cycles then err, then recover
        @(negedge sys_clk);
        clear_log();
        req(1, 8'h44, 8'h55);
        run_txn(1, 120, -1, -1);
        check("to_done_gap", done_cyc - send_cyc, 52);
        check("to_err_v", 32'(err_v), 2);
        @(negedge sys_clk);
        clear_log();
        req(0, 8'h01, 8'h02);
        run_txn(1, 40, 3, -1);
        check("to_next_err", 32'(err_v), 0);
        check("to_next_send", n_send, 1);
`endif

        // bus error during WAIT_TX, then fault mode
        @(negedge sys_clk);
        clear_log();
        req(0, 8'h0C, 8'h0D);
        run_txn(1, 40, -1, 5);
        check("er_done_gap", done_cyc - send_cyc, 6);
        check("er_done_v", 32'(done_v), 1);
        check("er_err_v", 32'(err_v), 1);
        clear_log();
        req(1, 8'h0E, 8'h0F);
        run_txn(1, 20, -1, -1);
        check("fl1_err_v", 32'(err_v), 2);
        check("fl1_lat", done_cyc - rdy_cyc, 1);
        check("fl1_no_bus", st_q.size() + n_send, 0);
        check("fl1_busy", 32'(busy), 0);
        @(negedge sys_clk);
        clear_log();
        req(0, 8'h0E, 8'h0F);
        run_txn(1, 20, -1, -1);
        check("fl0_err_v", 32'(err_v), 1);
        check("fl0_done_v", 32'(done_v), 1);
        check("fl0_no_bus", st_q.size() + n_send, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sccb_write_arbiter.md
Name: sccb_write_arbiter

Overview:
Shares the single i2c_control_fsm byte/store/send interface between NUM_REQ independent register-write requesters, e.g. the ROM init sequencer and runtime exposure/AGC tweakers.
- Round-robin arbitration among requesters.
- Each granted request is serialized as register-index byte, then value byte, then send pulse.
- Waits for device_rdy or error, then returns done/err to the owning requester.
- Sits between the camera control top level and i2c_control_fsm, on the sys_clk domain.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
IDX_W, $clog2(NUM_REQ) (min 1), grant index width
TIMEOUT_CYCLES, 2700000, transfer watchdog limit in sys_clk cycles (only with SCCB_TIMEOUT_EN; 100 ms at 27 MHz)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester write request; held until req_ready
req_reg_addr  in  NUM_REQ*8  flattened register index, slot i = [8i+7:8i]
req_reg_val  in  NUM_REQ*8  flattened register value
req_ready  out  NUM_REQ  one-cycle grant/accept pulse; addr/val captured this cycle
req_done  out  NUM_REQ  one-cycle completion pulse to owner
req_err  out  NUM_REQ  one-cycle error flag, coincident with req_done
ctrl_init_done_i  in  1  i2c_control_fsm init_done
ctrl_data_o  out  8  to fsm data_in
ctrl_store_o  out  1  to fsm store_data
ctrl_send_o  out  1  to fsm send_data
ctrl_device_rdy_i  in  1  fsm device_rdy
ctrl_error_i  in  1  fsm error_o (sticky in fsm)
busy_o  out  1  transaction in flight
grant_idx_o  out  IDX_W  index of current/last owner

Behaviour:
- Reset values: all outputs 0. rr pointer = 0. State IDLE.
- States: IDLE, ARB, STORE_ADDR, STORE_VAL, STORE_END, SEND, SEND_END, WAIT_TX, COMPLETE, FAULT.
- IDLE: if ctrl_init_done_i is 0, stay. Else if ctrl_error_i is 1, go to FAULT. Else if any req_valid, go to ARB.
- ARB:
  - Pick the first valid requester searching from rr pointer upward, with wrap (mod NUM_REQ).
  - Assert req_ready[g] for exactly this cycle. Latch addr/val and grant_idx_o=g. Set busy_o=1.
  - Set rr pointer = (g+1) mod NUM_REQ. Go to STORE_ADDR.
  - If valid dropped in that cycle (illegal), return to IDLE with no ready pulse.
- STORE_ADDR: ctrl_store_o=1, ctrl_data_o=latched addr.
- STORE_VAL: ctrl_store_o=1, ctrl_data_o=latched val.
- STORE_END: ctrl_store_o=0.
- SEND: ctrl_send_o=1 for one cycle.
- SEND_END: ctrl_send_o=0. device_rdy is not sampled in SEND or SEND_END; this guards against a stale ready.
- WAIT_TX: ctrl_error_i=1 -> COMPLETE with err. Else ctrl_device_rdy_i=1 -> COMPLETE ok. Error wins if both are set in the same cycle.
- COMPLETE: pulse req_done[g], and req_err[g] if error. busy_o=0. Next state is FAULT if error, else IDLE.
- Latency: ARB to first store = 1 cycle. Minimum ready-to-done = 7 cycles plus bus time.
- ctrl_data_o holds its last value outside STORE states.
- FAULT (terminal until reset): any valid requester, picked round-robin, gets req_ready and, next cycle, req_done+req_err. No bus activity.
- New req_valid during a transaction waits; there is no preemption. A requester may re-request in the cycle after its done pulse; round-robin still favours others.
- Reset mid-transaction: all strobes drop immediately and asynchronously. The partial write is lost and no done pulse is issued.
- ctrl_init_done_i falling outside IDLE is ignored.

Optional Feature:
SCCB_TIMEOUT_EN
- Defined: a 22-bit counter clears on entering WAIT_TX and increments each WAIT_TX cycle. On reaching TIMEOUT_CYCLES-1 without rdy/error, the block goes to COMPLETE with err=1, then returns to IDLE (not FAULT, since the fsm error may not be latched).
- Undefined: no counter. WAIT_TX may wait indefinitely.

Decomposition:
- Package sccb_arb_pkg holds:
  - state typedef (enum of the 10 states)
  - TOKEN-free constants: DATA_W=8
  - default TIMEOUT_CYCLES
  - function rr_pick(valid, ptr) returning the index.
- One sub-module is natural: rr_arbiter (combinational pick plus registered pointer, NUM_REQ-parameterized), reusable for a later read path.

Test Plan:
- Single write: init_done=1, req0 addr 0x12 val 0x80, rdy returned 20 cycles after send.
  - req_ready[0] 1 cycle after valid.
  - ctrl_data 0x12 then 0x80 on two store cycles.
  - One send pulse.
  - req_done[0]=1, req_err[0]=0 on the cycle after rdy.
- Contention: req0 and req1 both continuously valid for 4 transactions.
  - Grant order 0,1,0,1. No done lost. busy_o never glitches low mid-transaction.
- Stale ready: device_rdy held 1 throughout.
  - No completion before WAIT_TX. done exactly 2 cycles after the send pulse cycle end.
- Error: error_i=1 during WAIT_TX.
  - req_done+req_err to owner.
  - Next request on either port gets ready, then done+err, with no store/send strobes.
- Reset mid-op: deassert sys_rst_n during STORE_VAL.
  - Outputs 0 asynchronously.
  - After release, req0 write (0x3A,0x04) completes normally.
- Timeout (SCCB_TIMEOUT_EN, TIMEOUT_CYCLES=50): no rdy.
  - req_err after 50 WAIT_TX cycles. Next request proceeds normally.
